// File: rtl/blockade_video_timing.sv
// Raster timing generator: cascaded horizontal/vertical counters with 74163-style
// synchronous clear and terminal-count carry, plus registered sync/blank decodes.
module blockade_video_timing #(
    parameter int H_TOTAL      = 320,
    parameter int H_ACTIVE     = 256,
    parameter int H_SYNC_START = 272,
    parameter int H_SYNC_END   = 296,
    parameter int V_TOTAL      = 262,
    parameter int V_ACTIVE     = 224,
    parameter int V_SYNC_START = 240,
    parameter int V_SYNC_END   = 243
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ce,
    input  logic       _clear,
    output logic [8:0] hcnt,
    output logic [8:0] vcnt,
    output logic       hsync,
    output logic       vsync,
    output logic       hblank,
    output logic       vblank,
    output logic       line_end,
    output logic       frame_end
);

    localparam logic [8:0] H_LAST = 9'(H_TOTAL - 1);
    localparam logic [8:0] V_LAST = 9'(V_TOTAL - 1);

    generate
        if (!(H_ACTIVE < H_SYNC_START && H_SYNC_START < H_SYNC_END &&
              H_SYNC_END <= H_TOTAL && H_TOTAL <= 512)) begin : g_bad_h_params
            $error("blockade_video_timing: illegal H_* parameter ordering");
        end
        if (!(V_ACTIVE < V_SYNC_START && V_SYNC_START < V_SYNC_END &&
              V_SYNC_END <= V_TOTAL && V_TOTAL <= 512)) begin : g_bad_v_params
            $error("blockade_video_timing: illegal V_* parameter ordering");
        end
    endgenerate

    logic [8:0] h_next;
    logic [8:0] v_next;
    logic       v_term;

    // Terminal-count decodes act as the ripple carry between the two counters.
    assign line_end  = (hcnt == H_LAST);
    assign v_term    = (vcnt == V_LAST);
    assign frame_end = line_end && v_term;

    always_comb begin
        h_next = hcnt;
        v_next = vcnt;
        if (ce) begin
            if (!_clear) begin
                h_next = '0;
                v_next = '0;
            end else if (line_end) begin
                h_next = '0;
                v_next = v_term ? 9'd0 : vcnt + 9'd1;
            end else begin
                h_next = hcnt + 9'd1;
            end
        end
    end

    // Decodes are taken from the next counts so they line up with the counts they describe.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hcnt   <= '0;
            vcnt   <= '0;
            hsync  <= 1'b0;
            vsync  <= 1'b0;
            hblank <= 1'b0;
            vblank <= 1'b0;
        end else if (ce) begin
            hcnt   <= h_next;
            vcnt   <= v_next;
            hblank <= (int'(h_next) >= H_ACTIVE);
            hsync  <= (int'(h_next) >= H_SYNC_START) && (int'(h_next) < H_SYNC_END);
            vblank <= (int'(v_next) >= V_ACTIVE);
            vsync  <= (int'(v_next) >= V_SYNC_START) && (int'(v_next) < V_SYNC_END);
        end
    end

endmodule

// File: tb/tb_blockade_video_timing.sv
// Bench for blockade_video_timing: a default-parameter instance walked through a full
// frame, and a small-raster instance for clear, async reset and random-ce frames.
module tb_blockade_video_timing;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset_d, ce_d, clr_d;
    logic [8:0] hcnt_d, vcnt_d;
    logic       hsync_d, vsync_d, hblank_d, vblank_d, line_end_d, frame_end_d;

    logic       reset_s, ce_s, clr_s;
    logic [8:0] hcnt_s, vcnt_s;
    logic       hsync_s, vsync_s, hblank_s, vblank_s, line_end_s, frame_end_s;

    blockade_video_timing dut (
        .clk(clk), .reset(reset_d), .ce(ce_d), ._clear(clr_d),
        .hcnt(hcnt_d), .vcnt(vcnt_d), .hsync(hsync_d), .vsync(vsync_d),
        .hblank(hblank_d), .vblank(vblank_d), .line_end(line_end_d), .frame_end(frame_end_d)
    );

    blockade_video_timing #(
        .H_TOTAL(24), .H_ACTIVE(16), .H_SYNC_START(18), .H_SYNC_END(21),
        .V_TOTAL(10), .V_ACTIVE(7), .V_SYNC_START(8), .V_SYNC_END(9)
    ) dut_s (
        .clk(clk), .reset(reset_s), .ce(ce_s), ._clear(clr_s),
        .hcnt(hcnt_s), .vcnt(vcnt_s), .hsync(hsync_s), .vsync(vsync_s),
        .hblank(hblank_s), .vblank(vblank_s), .line_end(line_end_s), .frame_end(frame_end_s)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int sel;
    // Reference model: a linear pixel position within the frame; h and v derived by div/mod.
    int pos[2];
    int wraps[2];
    int fe_cnt[2];
    int ht[2], ha[2], hss[2], hse[2], vt[2], va[2], vss[2], vse[2];

    task automatic chk(input string tag, input logic [8:0] obs, input logic [8:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0d expected=%0d inst=%0d pos=%0d", tag, obs, exp, sel, pos[sel]);
        end
    endtask

    task automatic check_all();
        int h, v;
        logic [8:0] o_h, o_v;
        logic o_hs, o_vs, o_hb, o_vb, o_le, o_fe;
        h = pos[sel] % ht[sel];
        v = pos[sel] / ht[sel];
        if (sel == 0) begin
            o_h = hcnt_d; o_v = vcnt_d; o_hs = hsync_d; o_vs = vsync_d;
            o_hb = hblank_d; o_vb = vblank_d; o_le = line_end_d; o_fe = frame_end_d;
        end else begin
            o_h = hcnt_s; o_v = vcnt_s; o_hs = hsync_s; o_vs = vsync_s;
            o_hb = hblank_s; o_vb = vblank_s; o_le = line_end_s; o_fe = frame_end_s;
        end
        chk("hcnt", o_h, 9'(h));
        chk("vcnt", o_v, 9'(v));
        chk("hblank", {8'd0, o_hb}, {8'd0, (h >= ha[sel])});
        chk("hsync", {8'd0, o_hs}, {8'd0, (h >= hss[sel] && h < hse[sel])});
        chk("vblank", {8'd0, o_vb}, {8'd0, (v >= va[sel])});
        chk("vsync", {8'd0, o_vs}, {8'd0, (v >= vss[sel] && v < vse[sel])});
        chk("line_end", {8'd0, o_le}, {8'd0, (h == ht[sel] - 1)});
        chk("frame_end", {8'd0, o_fe}, {8'd0, (pos[sel] == ht[sel] * vt[sel] - 1)});
    endtask

    task automatic step(input logic ce_v, input logic clr_v);
        logic fe_before, rst_now;
        @(negedge clk);
        if (sel == 0) begin
            ce_d = ce_v; clr_d = clr_v; ce_s = 1'b0; clr_s = 1'b1;
            fe_before = frame_end_d;
        end else begin
            ce_s = ce_v; clr_s = clr_v; ce_d = 1'b0; clr_d = 1'b1;
            fe_before = frame_end_s;
        end
        @(posedge clk);
        rst_now = (sel == 0) ? reset_d : reset_s;
        if (ce_v && !rst_now) begin
            if (fe_before) fe_cnt[sel]++;
            if (!clr_v) begin
                pos[sel] = 0;
            end else if (pos[sel] == ht[sel] * vt[sel] - 1) begin
                pos[sel] = 0;
                wraps[sel]++;
            end else begin
                pos[sel] = pos[sel] + 1;
            end
        end
        #1;
        check_all();
    endtask

    initial begin
        ht[0] = 320; ha[0] = 256; hss[0] = 272; hse[0] = 296;
        vt[0] = 262; va[0] = 224; vss[0] = 240; vse[0] = 243;
        ht[1] = 24;  ha[1] = 16;  hss[1] = 18;  hse[1] = 21;
        vt[1] = 10;  va[1] = 7;   vss[1] = 8;   vse[1] = 9;
        for (int i = 0; i < 2; i++) begin
            pos[i] = 0; wraps[i] = 0; fe_cnt[i] = 0;
        end

        // Reset state of both instances
        reset_d = 1'b1; ce_d = 1'b0; clr_d = 1'b1;
        reset_s = 1'b1; ce_s = 1'b0; clr_s = 1'b1;
        #2;
        sel = 0; check_all();
        sel = 1; check_all();
        @(negedge clk);
        reset_d = 1'b0;
        reset_s = 1'b0;

        // Default raster: one line at full rate, then one line with ce every 4th clk
        sel = 0;
        for (int i = 0; i < 320; i++) step(1'b1, 1'b1);
        chk("vcnt_after_line", vcnt_d, 9'd1);
        for (int i = 0; i < 320; i++) begin
            step(1'b1, 1'b1);
            step(1'b0, 1'b1);
            step(1'b0, 1'b0);
            step(1'b0, 1'b1);
        end
        // Remainder of the frame at full rate, then clear on the terminal count
        for (int i = 0; i < 90000 && pos[0] != 320 * 262 - 1; i++) step(1'b1, 1'b1);
        step(1'b1, 1'b0);
        chk("fe_count_default", 9'(fe_cnt[0]), 9'd1);
        step(1'b1, 1'b1);

        // Small raster: clear mid-frame with ce low (ignored) then ce high
        sel = 1;
        for (int i = 0; i < 1000 && pos[1] != 5 * 24 + 10; i++) step(1'b1, 1'b1);
        step(1'b0, 1'b0);
        step(1'b1, 1'b0);
        for (int i = 0; i < 1000 && pos[1] != 239; i++) step(1'b1, 1'b1);
        step(1'b1, 1'b0);
        step(1'b1, 1'b1);

        // Asynchronous reset between edges mid-frame
        for (int i = 0; i < 1000 && pos[1] != 6 * 24 + 20; i++) step(1'b1, 1'b1);
        #2;
        reset_s = 1'b1;
        #1;
        pos[1] = 0;
        check_all();
        step(1'b1, 1'b1);
        reset_s = 1'b0;
        step(1'b1, 1'b1);
        chk("hcnt_after_reset", hcnt_s, 9'd1);

        // Random ce over three frames
        fe_cnt[1] = 0;
        wraps[1] = 0;
        for (int i = 0; i < 20000 && wraps[1] < 3; i++) step(1'($urandom_range(0, 1)), 1'b1);
        chk("fe_count_random", 9'(fe_cnt[1]), 9'd3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/blockade_video_timing.md
Name: blockade_video_timing

Overview:
Raster timing generator built from two cascaded synchronous binary counters, horizontal and vertical, each with 74163-style synchronous clear and terminal-count behaviour. It consumes the pixel clock-enable and produces the pixel and line counts, sync, blank and end-of-line/frame strobes. Video RAM address logic, sprite/character logic and the video output stage consume these outputs.

Parameters:
H_TOTAL, 320, pixels per line (counter range 0..H_TOTAL-1)
H_ACTIVE, 256, visible pixels; hblank asserted for hcnt >= H_ACTIVE
H_SYNC_START, 272, first hcnt with hsync asserted
H_SYNC_END, 296, first hcnt with hsync deasserted
V_TOTAL, 262, lines per frame (range 0..V_TOTAL-1)
V_ACTIVE, 224, visible lines; vblank asserted for vcnt >= V_ACTIVE
V_SYNC_START, 240, first vcnt with vsync asserted
V_SYNC_END, 243, first vcnt with vsync deasserted

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
ce  input  1  pixel clock enable; all state advances only when high
_clear  input  1  active-low synchronous restart; qualified by ce
hcnt  output  9  horizontal pixel count
vcnt  output  9  vertical line count
hsync  output  1  active-high horizontal sync
vsync  output  1  active-high vertical sync
hblank  output  1  horizontal blank
vblank  output  1  vertical blank
line_end  output  1  high while hcnt == H_TOTAL-1 (ripple carry into vertical counter)
frame_end  output  1  high while hcnt == H_TOTAL-1 and vcnt == V_TOTAL-1

Behaviour:
- Reset, asynchronous: hcnt=0, vcnt=0, hsync=0, vsync=0, hblank=0, vblank=0. line_end=0 and frame_end=0 follow from the counts.
- No state changes when ce=0. Outputs hold.
- Priority on each ce=1 clock edge, highest first:
  1. _clear=0: hcnt<=0, vcnt<=0.
  2. hcnt==H_TOTAL-1: hcnt<=0.
     - If vcnt==V_TOTAL-1: vcnt<=0.
     - Otherwise: vcnt<=vcnt+1.
  3. Otherwise: hcnt<=hcnt+1, vcnt holds.
- _clear=0 with ce=0 has no effect, matching 74163 synchronous clear gated by the enable.
- Counters are 9-bit unsigned. Wrap is by terminal-count compare, never by natural 2^9 overflow. Counts never reach H_TOTAL or V_TOTAL.
- hsync, vsync, hblank, vblank are registered. They are computed from the next count values so they align exactly with the hcnt/vcnt presented in the same cycle, with zero relative latency:
  - hblank = (hcnt >= H_ACTIVE)
  - hsync = (H_SYNC_START <= hcnt < H_SYNC_END)
  - vblank = (vcnt >= V_ACTIVE)
  - vsync = (V_SYNC_START <= vcnt < V_SYNC_END)
- line_end and frame_end are combinational decodes of the registered counts, like 74163 RCO. Each is high for exactly one ce period per line or frame.
- Reset asserted mid-frame: all outputs go to reset values immediately, without waiting for clk. After release, counting restarts from 0,0 at the first ce=1 edge, giving hcnt=1.
- _clear=0 at the terminal count: the clear wins and there is no extra vcnt increment.
- Parameter legality, checked by simulation assertion only: H_ACTIVE < H_SYNC_START < H_SYNC_END <= H_TOTAL <= 512. Same ordering applies to the V_* set.

Test Plan:
- Reset, then ce=1 every cycle for 320 cycles -> hcnt runs 0..319, wraps to 0, vcnt becomes 1; line_end high only at hcnt=319.
- ce high every 4th clk -> each hcnt value is held for 4 clks; timing in ce units is identical to the ce=1 case.
- Full frame of 320*262 ce pulses -> frame_end pulses once at (319,261), then counts are (0,0). Also check: vblank high for vcnt 224..261, vsync high for vcnt 240..242, hsync high for hcnt 272..295, hblank high for hcnt 256..319.
- _clear=0 at (100,50) with ce=1 -> next counts (0,0). _clear=0 with ce=0 -> counts unchanged. _clear=0 at (319,261) -> (0,0), with no vcnt overflow artefact.
- Assert reset asynchronously at (200,230) between clk edges -> all outputs 0 before the next edge. Release reset -> hcnt=1 after the first ce edge.
- Random ce pattern over 3 frames -> scoreboard confirms sync/blank alignment with the counts and exactly 3 frame_end pulses.
